// File: rtl/rgb_color_ctrl.sv
// rgb_color_ctrl: debounced load button captures the switch color; the committed color drives the VGA pins.
// Define COLOR_FRAME_SYNC_EN to defer each commit to the next frame_tick (tear-free update).
module rgb_color_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       btn,
  input  logic       video_on,
  input  logic       frame_tick,
  output logic [2:0] rgb_out,
  output logic [2:0] color_reg,
  output logic       pending,
  output logic       btn_evt
);

  localparam int unsigned COLOR_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               btn_meta;
  logic               btn_s;
  logic [COLOR_W-1:0] sw_meta;
  logic [COLOR_W-1:0] sw_s;
  logic [COLOR_W-1:0] pending_color;
  logic               capture_c;

  // Two-flop synchronizers for the asynchronous button and switches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
      sw_meta  <= {sw3, sw2, sw1};
      sw_s     <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Debounce: a level is accepted after DEBOUNCE_CYCLES stable cycles; counter saturates, never wraps
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture_c  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (btn_s) state_next = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = HELD;
          cnt_next   = '0;
          capture_c  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        cnt_next = '0;
        if (!btn_s) state_next = REL_CHK;
      end
      REL_CHK: begin
        if (btn_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifndef COLOR_FRAME_SYNC_EN
  logic frame_tick_unused;
  assign frame_tick_unused = frame_tick;
`endif

  // Capture has priority over commit so a same-cycle frame_tick never commits a stale color
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_out       <= '0;
      color_reg     <= '0;
      pending_color <= '0;
      pending       <= 1'b0;
      btn_evt       <= 1'b0;
    end else begin
      btn_evt <= capture_c;
      rgb_out <= video_on ? color_reg : '0;
      if (capture_c) begin
        pending_color <= sw_s;
        pending       <= 1'b1;
`ifdef COLOR_FRAME_SYNC_EN
      end else if (frame_tick && pending) begin
`else
      end else if (pending) begin
`endif
        color_reg <= pending_color;
        pending   <= 1'b0;
      end
    end
  end

endmodule
